// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative HI/LO multiply/divide unit.
//
// Multiplies with a radix-2 shift-add loop and divides with a radix-2
// restoring shift-subtract loop, one step per clock, on operand magnitudes.
// The signs are applied in a single fix-up cycle before HI/LO are written.
// While the unit is idle, or in its done cycle, HI and LO can be written
// directly (mthi/mtlo).
//
// Ports
//   clock    rising-edge clock
//   reset    synchronous, active-high reset
//   start    begin an operation (accepted only in IDLE)
//   op       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_data  multiplicand / dividend
//   rt_data  multiplier / divisor
//   hi_we    write wr_data to HI (mthi)
//   lo_we    write wr_data to LO (mtlo)
//   wr_data  data for mthi/mtlo
//   busy     high during CALC and FIX
//   done     one-cycle pulse when HI/LO hold a new result
//   hi, lo   HI/LO registers
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; mthi/mtlo writes accepted
// CALC   | one radix-2 step per cycle, 32 cycles
// FIX    | sign correction, HI/LO written at the end of the cycle
// DONE   | done pulse for one cycle; mthi/mtlo accepted; start ignored
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  // acc_hi holds the running partial product / partial remainder; the extra
  // bit absorbs the carry of the add or the shifted-in remainder bit.
  logic [WIDTH:0]   acc_hi_q, acc_hi_d;
  // acc_lo holds the multiplier (shifted out LSB first) or the dividend
  // (shifted out MSB first, quotient bits shifted in).
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             is_div_q, is_div_d;
  logic             div_zero_q, div_zero_d;
  logic             lo_neg_q, lo_neg_d;
  logic             hi_neg_q, hi_neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             is_signed;
  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic [2*WIDTH-1:0] prod_raw, product;
  logic [WIDTH-1:0] quot, rem;

  // Operand decode and per-step datapath.
  always_comb begin
    is_signed = ~op[0];
    rs_neg    = is_signed & rs_data[WIDTH-1];
    rt_neg    = is_signed & rt_data[WIDTH-1];
    // 0x80000000 negates to itself, which read unsigned is the correct 2^31.
    rs_mag    = rs_neg ? -rs_data : rs_data;
    rt_mag    = rt_neg ? -rt_data : rt_data;

    mul_sum   = acc_lo_q[0] ? (acc_hi_q + {1'b0, opnd_q}) : acc_hi_q;

    div_shift = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
    // One extra bit so the borrow shows up as the sign of the trial result.
    div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};

    prod_raw  = {acc_hi_q[WIDTH-1:0], acc_lo_q};
    product   = lo_neg_q ? -prod_raw : prod_raw;
    quot      = acc_lo_q;
    rem       = acc_hi_q[WIDTH-1:0];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    opnd_d     = opnd_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    is_div_d   = is_div_q;
    div_zero_d = div_zero_q;
    lo_neg_d   = lo_neg_q;
    hi_neg_d   = hi_neg_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_div_d   = op[1];
          div_zero_d = op[1] && (rt_data == '0);
          acc_hi_d   = '0;
          acc_lo_d   = rs_mag;
          opnd_d     = rt_mag;
          // lo_neg: product sign or quotient sign; hi_neg: product sign or
          // remainder sign (follows the dividend).
          lo_neg_d   = rs_neg ^ rt_neg;
          hi_neg_d   = op[1] ? rs_neg : (rs_neg ^ rt_neg);
          cnt_d      = '0;
          state_d    = (op[1] && (rt_data == '0)) ? S_FIX : S_CALC;
        end else begin
          // A start in the same cycle wins; the write is dropped.
          if (hi_we) hi_d = wr_data;
          if (lo_we) lo_d = wr_data;
        end
      end

      S_CALC: begin
        if (is_div_q) begin
          if (div_diff[WIDTH+1]) begin
            acc_hi_d = div_shift;
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
          end else begin
            acc_hi_d = div_diff[WIDTH:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
          end
        end else begin
          acc_hi_d = {1'b0, mul_sum[WIDTH:1]};
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        if (cnt_q == 6'(WIDTH - 1)) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end

      S_FIX: begin
        if (div_zero_q) begin
          // acc_lo still holds |rs|; re-applying the dividend sign restores rs.
          lo_d = '1;
          hi_d = hi_neg_q ? -acc_lo_q : acc_lo_q;
        end else if (is_div_q) begin
          lo_d = lo_neg_q ? -quot : quot;
          hi_d = hi_neg_q ? -rem : rem;
        end else begin
          lo_d = product[WIDTH-1:0];
          hi_d = product[2*WIDTH-1:WIDTH];
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        if (hi_we) hi_d = wr_data;
        if (lo_we) lo_d = wr_data;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_CALC) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      is_div_q   <= 1'b0;
      div_zero_q <= 1'b0;
      lo_neg_q   <= 1'b0;
      hi_neg_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      opnd_q     <= opnd_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      is_div_q   <= is_div_d;
      div_zero_q <= div_zero_d;
      lo_neg_q   <= lo_neg_d;
      hi_neg_q   <= hi_neg_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases followed by
// randomized operations compared against an arithmetic reference model.
module tb_mult_div_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] m_hi    = '0;
  logic [31:0] m_lo    = '0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_data(rs_data),
    .rt_data(rt_data),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .wr_data(wr_data),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  // Reference: 64-bit arithmetic on sign- or zero-extended operands.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el);
    logic signed [63:0] sa, sb, sr, sq;
    logic [63:0]        ua, ub, ur, uq;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    eh = '0;
    el = '0;
    case (o)
      2'b00: begin sr = sa * sb; eh = sr[63:32]; el = sr[31:0]; end
      2'b01: begin ur = ua * ub; eh = ur[63:32]; el = ur[31:0]; end
      2'b10: begin
        if (b == 0) begin eh = a; el = 32'hFFFF_FFFF; end
        else begin sq = sa / sb; sr = sa % sb; el = sq[31:0]; eh = sr[31:0]; end
      end
      default: begin
        if (b == 0) begin eh = a; el = 32'hFFFF_FFFF; end
        else begin uq = ua / ub; ur = ua % ub; el = uq[31:0]; eh = ur[31:0]; end
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 255);
      default: return $urandom;
    endcase
  endfunction

  // Issues one operation and follows it to completion.
  //   intf : cycle N+intf gets start+hi_we+lo_we with junk (0 = none)
  //   wws  : assert hi_we/lo_we together with start (write must be dropped)
  //   dwr  : perform an mthi/mtlo write during the DONE cycle
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input int intf, input bit wws, input bit dwr);
    logic [31:0] eh, el, w;
    int          lat, exp_lat, busy_cnt;
    bit          held;
    model(o, a, b, eh, el);
    exp_lat = (o[1] && b == 0) ? 2 : 34;
    @(negedge clock);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    hi_we = wws; lo_we = wws; wr_data = $urandom;
    @(negedge clock);
    lat = 0; busy_cnt = 0; held = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      if (done === 1'b1) begin lat = k; break; end
      if (busy === 1'b1) busy_cnt++;
      if (hi !== m_hi || lo !== m_lo) held = 1'b0;
      op = 2'($urandom); rs_data = $urandom; rt_data = $urandom;
      if (k == intf) begin
        start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wr_data = $urandom;
      end
      @(negedge clock);
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
    check({tag, "_hold"}, 64'(held), 64'd1);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_hi"}, 64'(hi), 64'(eh));
    check({tag, "_lo"}, 64'(lo), 64'(el));
    m_hi = eh; m_lo = el;
    if (dwr) begin
      w = $urandom;
      hi_we = 1'b1; lo_we = 1'($urandom); wr_data = w;
      m_hi = w;
      if (lo_we) m_lo = w;
    end
    @(negedge clock);
    hi_we = 1'b0; lo_we = 1'b0;
    check({tag, "_done_pulse"}, {62'd0, done, busy}, 64'd0);
    check({tag, "_after_hi"}, 64'(hi), 64'(m_hi));
    check({tag, "_after_lo"}, 64'(lo), 64'(m_lo));
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    bit          seen;
    reset = 1'b1; start = 1'b0; op = '0; rs_data = '0; rt_data = '0;
    hi_we = 1'b0; lo_we = 1'b0; wr_data = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("reset_state", {hi, lo}, 64'd0);
    check("reset_flags", {62'd0, busy, done}, 64'd0);

    // mthi/mtlo in IDLE, both and single
    hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'h1357_9BDF;
    @(negedge clock);
    hi_we = 1'b0; lo_we = 1'b0;
    m_hi = 32'h1357_9BDF; m_lo = 32'h1357_9BDF;
    check("mt_both", {hi, lo}, {m_hi, m_lo});
    lo_we = 1'b1; wr_data = 32'h0BAD_F00D;
    @(negedge clock);
    lo_we = 1'b0;
    m_lo = 32'h0BAD_F00D;
    check("mtlo_only", {hi, lo}, {m_hi, m_lo});

    run_op(2'b00, 32'hFFFF_FFFD, 32'd7,        "mult_neg3x7",   0, 0, 0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max",    0, 0, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2,        "div_neg7by2",   0, 0, 0);
    run_op(2'b11, 32'd100,       32'd7,        "divu_100by7",   0, 0, 0);
    run_op(2'b11, 32'h0000_1234, 32'd0,        "divu_by0",      0, 0, 0);
    run_op(2'b10, 32'hFFFF_FF00, 32'd0,        "div_neg_by0",   0, 0, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_by_m1", 0, 0, 0);
    run_op(2'b00, 32'd5,         32'd6,        "mult_5x6_intf", 10, 0, 0);
    run_op(2'b01, 32'hDEAD_BEEF, 32'h1234_5678, "start_with_we", 0, 1, 1);

    // Reset in the middle of a DIV, with start and hi_we competing
    @(negedge clock);
    start = 1'b1; op = 2'b10; rs_data = 32'd1000; rt_data = 32'd3;
    @(negedge clock);
    start = 1'b0;
    repeat (19) @(negedge clock);
    reset = 1'b1; start = 1'b1; hi_we = 1'b1; wr_data = 32'h5555_5555;
    @(negedge clock);
    reset = 1'b0; start = 1'b0; hi_we = 1'b0;
    m_hi = '0; m_lo = '0;
    check("midreset_flags", {62'd0, busy, done}, 64'd0);
    check("midreset_hilo", {hi, lo}, 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    check("midreset_no_done", 64'(seen), 64'd0);
    lo_we = 1'b1; wr_data = 32'hA5A5_A5A5;
    @(negedge clock);
    lo_we = 1'b0;
    m_lo = 32'hA5A5_A5A5;
    check("midreset_mtlo", {hi, lo}, {m_hi, m_lo});

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = pick();
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
      run_op(ro, ra, rb, $sformatf("rand%0d", i),
             ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 33)) : 0,
             1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
